// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder producing sum, carry-out and signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic c, s, cn, last;
  assign s = ra[0] ^ rb[0] ^ c;
  assign cn = ((ra[0] ^ rb[0]) & c) | (ra[0] & rb[0]);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == ADD;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state: ADD runs WIDTH cycles, DONE lasts one cycle
  always_comb
    state_n = state == IDLE ? (start ? ADD : IDLE) : state == ADD ? (last ? DONE : ADD) : IDLE;
  // datapath: load on accepted start, one bit per ADD cycle, capture flags on the MSB
  always_ff @(posedge clk)
    if (reset) begin
      ra <= '0;
      rb <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      ra <= a;
      rb <= b;
      c <= cin;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (state == ADD) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      c <= cn;
      cnt <= cnt + 1'b1;
      sum <= {s, sum[WIDTH-1:1]};
      if (last) begin
        cout <= cn;
        overflow <= c ^ cn;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, scoreboard queue and directed corner cases for serial_adder
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset, start, cin, busy, done, cout, overflow;
  logic [W-1:0] a, b, sum;
  typedef struct {logic [W-1:0] s; logic co; logic ov;} exp_t;
  typedef struct {logic [W-1:0] a, b; logic ci; logic [W-1:0] s; logic co, ov;} vec_t;
  exp_t q[$];
  vec_t tv[7];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.co = t[W];
    e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // one addition: optional idle gap, start, bounded wait for done, scoreboard compare;
  // poke raises start during ADD cycle 3 and during DONE (left high on return)
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                    input exp_t e, input int gap, input bit poke);
    exp_t g;
    int lat, nb;
    bit seen;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    start = 1'b1; a = x; b = y; cin = ci;
    q.push_back(e);
    lat = 0; nb = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = done;
      if (!seen && busy) nb++;
      if (seen) check("busy_in_done", busy, 0);
      start = poke && (lat == 3 || seen);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    check("done_seen", seen, 1);
    g = q.pop_front();
    check("sum", sum, g.s);
    check("cout", cout, g.co);
    check("overflow", overflow, g.ov);
    check("latency", lat, W + 1);
    check("busy_cycles", nb, W);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int nbusy, ndone;
    tv[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tv[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 7; i++)
      op(tv[i].a, tv[i].b, tv[i].ci, '{tv[i].s, tv[i].co, tv[i].ov}, i % 2, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_sum", sum, 8'h46);
    check("hold_busy", busy, 0);
    op(8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0}, 0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0;
    repeat (12) begin
      @(negedge clk);
      nbusy += int'(busy);
      ndone += int'(done);
    end
    check("ignored_busy", nbusy, 0);
    check("ignored_done", ndone, 0);
    check("ignored_hold_sum", sum, 8'h01);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_overflow", overflow, 0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("abort_no_done", ndone, 0);
    op(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0}, 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] x, y;
      logic ci;
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      op(x, y, ci, model(x, y, ci), (i % 3 == 0) ? 0 : int'($urandom_range(0, 3)), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
